// File: rtl/pscan_pkg.sv
// Shared types and constants for the pattern_scan_arbiter slice.
// Optional feature macro: PSCAN_FAIR_EN (round-robin arbitration).
package pscan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_t;

  typedef enum logic [2:0] {
    DET_A = 3'd0,
    DET_B = 3'd1,
    DET_C = 3'd2,
    DET_D = 3'd3,
    DET_E = 3'd4,
    DET_F = 3'd5
  } det_state_t;

  localparam logic [4:0] PATTERN = 5'b10010;

  // One-hot pick between two requesters; prefer1 breaks a tie toward requester 1.
  function automatic logic [1:0] arb_pick(input logic [1:0] req, input logic prefer1);
    logic [1:0] pick;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = prefer1 ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/seq_det_10010.sv
// Moore detector for the serial pattern 10010 with overlap; w is high in state F.
// Holds state while en is low; clr synchronously returns it to state A.
module seq_det_10010
  import pscan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic j,
  output logic w
);

  det_state_t r_state;

  // Detector state register: clear has priority over advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DET_A;
    end else if (clr) begin
      r_state <= DET_A;
    end else if (en) begin
      case (r_state)
        DET_A:   r_state <= j ? DET_B : DET_A;
        DET_B:   r_state <= j ? DET_B : DET_C;
        DET_C:   r_state <= j ? DET_B : DET_D;
        DET_D:   r_state <= j ? DET_E : DET_A;
        DET_E:   r_state <= j ? DET_B : DET_F;
        DET_F:   r_state <= j ? DET_B : DET_D;
        default: r_state <= DET_A;
      endcase
    end else begin
      r_state <= r_state;
    end
  end

  assign w = (r_state == DET_F);

endmodule

// File: rtl/pattern_scan_arbiter.sv
// Two-requester front end that serialises a word MSB-first through seq_det_10010
// and returns the overlapping match count. PSCAN_FAIR_EN selects round-robin ties.
module pattern_scan_arbiter
  import pscan_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [W-1:0]  data0,
  input  logic [W-1:0]  data1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [CW-1:0] count,
  output logic          busy
);

  localparam int BW = $clog2(W);

  fsm_state_t    r_state;
  logic [W-1:0]  r_shift;
  logic [BW-1:0] r_bit_cnt;
  logic [CW-1:0] r_match;
  logic [1:0]    r_gnt;
  logic [1:0]    r_done;
  logic [CW-1:0] r_count;
  logic          r_busy;

  logic [1:0] w_pick;
  logic       w_det_en;
  logic       w_det_clr;
  logic       w_det_j;
  logic       w_det_w;

`ifdef PSCAN_FAIR_EN
  logic r_last;

  assign w_pick = arb_pick(req, ~r_last);

  // Last-grant pointer; reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if ((r_state == ST_IDLE) && (req != 2'b00)) begin
      r_last <= w_pick[1];
    end else begin
      r_last <= r_last;
    end
  end
`else
  assign w_pick = arb_pick(req, 1'b0);
`endif

  // Clear lands on the grant edge so the first SHIFT cycle starts from state A.
  assign w_det_clr = (r_state == ST_IDLE) && (req != 2'b00);
  assign w_det_en  = (r_state == ST_SHIFT);
  assign w_det_j   = r_shift[W-1];

  seq_det_10010 u_det (
    .clk (clk),
    .rst (rst),
    .en  (w_det_en),
    .clr (w_det_clr),
    .j   (w_det_j),
    .w   (w_det_w)
  );

  // Control FSM with registered outputs; DRAIN folds in the last bit's match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_match   <= '0;
      r_gnt     <= 2'b00;
      r_done    <= 2'b00;
      r_count   <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            r_shift   <= (w_pick == 2'b10) ? data1 : data0;
            r_gnt     <= w_pick;
            r_bit_cnt <= '0;
            r_match   <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_shift <= {r_shift[W-2:0], 1'b0};
          r_match <= r_match + CW'(w_det_w);
          if (r_bit_cnt == BW'(W - 1)) begin
            r_state <= ST_DRAIN;
          end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1'b1);
          end
        end
        ST_DRAIN: begin
          r_match <= r_match + CW'(w_det_w);
          r_count <= r_match + CW'(w_det_w);
          r_done  <= r_gnt;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 2'b00;
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign count = r_count;
  assign busy  = r_busy;

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Randomised self-checking bench for pattern_scan_arbiter against a window-count
// reference model; arbitration expectations follow PSCAN_FAIR_EN.
module tb_pattern_scan_arbiter;
  import pscan_pkg::*;

  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          rst;
  logic [1:0]    req;
  logic [W-1:0]  data0;
  logic [W-1:0]  data1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [CW-1:0] count;
  logic          busy;

  int n_cmp;
  int n_err;
  int last_g;
  int prev_count;

  pattern_scan_arbiter #(.W(W), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data0 (data0),
    .data1 (data1),
    .gnt   (gnt),
    .done  (done),
    .count (count),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: number of 5-bit windows of the word (MSB first) equal to the pattern.
  function automatic int count_matches(input logic [W-1:0] d);
    int n;
    logic [4:0] win5;
    logic [4:0] pat;
    n = 0;
    pat = PATTERN;
    for (int i = W - 1; i >= 4; i--) begin
      win5 = d[i -: 5];
      if (win5 == pat) n++;
    end
    return n;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    req = 2'b00;
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    last_g = 1;
    prev_count = 0;
    @(negedge clk);
    check_eq("post_rst_busy", busy, 0);
  endtask

  task automatic do_job(input logic [1:0] rq, input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input bit keep, input int drop_at);
    int win;
    int exp_cnt;
    logic [1:0] oh;
    if (rq == 2'b11) begin
`ifdef PSCAN_FAIR_EN
      win = (last_g == 1) ? 0 : 1;
`else
      win = 0;
`endif
    end else begin
      win = rq[0] ? 0 : 1;
    end
    last_g  = win;
    oh      = (win == 0) ? 2'b01 : 2'b10;
    exp_cnt = count_matches((win == 0) ? d0 : d1);
    req   = rq;
    data0 = d0;
    data1 = d1;
    @(posedge clk);
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      check_eq("gnt", gnt, oh);
      check_eq("busy", busy, 1);
      if (c == W + 2) begin
        check_eq("done", done, oh);
        check_eq("count", count, exp_cnt);
      end else begin
        check_eq("done_early", done, 0);
        check_eq("count_hold", count, prev_count);
      end
      if (c == drop_at) req = 2'b00;
    end
    prev_count = exp_cnt;
    if (!keep) req = 2'b00;
    @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_gnt", gnt, 0);
    check_eq("idle_done", done, 0);
    check_eq("idle_count", count, prev_count);
  endtask

  task automatic reset_mid_job(input logic [W-1:0] d0);
    req   = 2'b01;
    data0 = d0;
    @(posedge clk);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_gnt", gnt, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_count", count, 0);
    req = 2'b00;
    last_g = 1;
    prev_count = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      check_eq("abort_no_done", done, 0);
      check_eq("abort_idle", busy, 0);
    end
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0] rq;
    int pos;
    n_cmp = 0;
    n_err = 0;
    last_g = 1;
    prev_count = 0;
    rst = 1'b1;
    req = 2'b00;
    data0 = '0;
    data1 = '0;

    apply_reset();

    do_job(2'b01, 16'b1001_0010_0000_0000, W'($urandom()), 1'b0, 0);
    do_job(2'b10, W'($urandom()), 16'b0000_0000_0001_0010, 1'b0, 0);
    do_job(2'b01, 16'hFFFF, 16'h0000, 1'b0, 0);
    do_job(2'b01, 16'h0000, 16'hFFFF, 1'b0, 0);
    do_job(2'b01, 16'b1001_0010_0100_1001, 16'h0000, 1'b0, 0);

    apply_reset();
    for (int k = 0; k < 4; k++) begin
      a = W'($urandom());
      b = W'($urandom());
      do_job(2'b11, a, b, (k < 3), 0);
    end

    reset_mid_job(16'b1001_0010_0100_1000);
    do_job(2'b01, 16'b0100_1000_0000_0000, 16'h0000, 1'b0, 0);

    do_job(2'b01, 16'b0000_1001_0010_0101, 16'h0000, 1'b0, 5);

    for (int k = 0; k < 30; k++) begin
      rq = 2'($urandom_range(1, 3));
      a = W'($urandom());
      b = W'($urandom());
      if ($urandom_range(0, 1) == 1) begin
        pos = $urandom_range(4, W - 1);
        a[pos -: 5] = PATTERN;
        pos = $urandom_range(4, W - 1);
        b[pos -: 5] = PATTERN;
      end
      do_job(rq, a, b, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, W) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_scan_arbiter.md
# pattern_scan_arbiter

- Shares one serial "10010" Moore pattern detector between two requesters.
- Each requester presents a W-bit word. The block grants one requester round-robin and shifts the word MSB-first through the detector.
- It counts overlapping matches and returns the count with a one-cycle done pulse.
- It sits between the parallel requesters and the bit-serial detector datapath. It owns the detector's enable and clear.

## Interface
- W, 16: word width in bits; W ≥ 5.
- CW, $clog2(W+1): width of the count output.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  2  per-requester request; held high with stable data until the matching done.
- data0  in  W  word for requester 0.
- data1  in  W  word for requester 1.
- gnt  out  2  one-hot grant; high from the first SHIFT cycle through DONE.
- done  out  2  one-cycle pulse to the granted requester in DONE.
- count  out  CW  match count; valid while done is high, holds until the next job's DONE.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SHIFT, DRAIN, DONE.
- IDLE:
  - If any req bit is high, arbitrate, latch the winner's word into the shift register, and set gnt.
  - Pulse detector clear, reset the bit counter and the match counter, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each cycle, present the shift-register MSB as detector input j with enable high, then shift left.
  - After W cycles, go to DRAIN.
- DRAIN: one cycle with detector enable low. It catches the detector output w produced by the last bit. Go to DONE.
- DONE: drive done[granted] = 1 and count = match counter. Clear gnt on exit. Return to IDLE.
- Match counting:
  - The match counter increments in every SHIFT or DRAIN cycle where w = 1.
  - Because of the detector clear, w = 0 in the first SHIFT cycle.
  - w is high for exactly one enabled bit period per match, because state F always exits on the next enabled bit.
- Overlapping matches count. Example: 10010010 gives 2.
- Arbitration:
  - A last-grant pointer updates at each grant.
  - On a tie, grant the requester not served last. After reset the pointer favors requester 0.
- req deasserted mid-job is ignored; the job completes and done still pulses.
- The detector does not advance while enable is low. The clear is synchronous and forces state A.
- The count cannot overflow: CW covers W.

## Timing
- Reset values: gnt = 00, done = 00, count = 0, busy = 0, FSM = IDLE, detector = A, last-grant pointer = 1.
- req sampled high in IDLE at edge k gives:
  - SHIFT from edge k through k+W−1;
  - DRAIN at edge k+W;
  - DONE at edge k+W+1, so done is visible in that cycle.
- Latency from request sample to done pulse: W+2 cycles.
- A pending req is re-arbitrated in the IDLE cycle after DONE. Back-to-back jobs are therefore separated by one IDLE cycle.
- Reset asserted mid-job aborts it: all outputs return to reset values, no done is emitted, and the requester must re-request.
- A detector output w is registered (Moore); the count reflects bits up to and including the last bit shifted.

## Configuration
- PSCAN_FAIR_EN defined: round-robin arbitration as above.
- PSCAN_FAIR_EN undefined: fixed priority, requester 0 always wins ties. The last-grant pointer is not built.

## Structure
- Package pscan_pkg:
  - FSM state enum;
  - detector state encodings A–F (3-bit);
  - constant PATTERN = 5'b10010.
- Sub-module seq_det_10010:
  - Moore detector with inputs clk, rst, en, clr, j and output w;
  - transitions A→B/A, B→B/C, C→B/D, D→E/A, E→B/F, F→B/D (j = 1 / j = 0);
  - w = (state == F).
- The top level holds the arbiter, shift register, bit counter, match counter and control FSM.

## Test plan
- W=16; req=01 with data0=16'b1001_0010_0000_0000 → gnt=01 for 18 cycles, done=01 at W+2, count=2.
- req=10 with data1=16'b0000_0000_0001_0010 (pattern in last bits) → count=1, which proves DRAIN catches the final match.
- data0=16'hFFFF, then 16'h0000 → count=0 both times, and busy drops to 0 after each DONE.
- req=11 held after reset → first grant to requester 0, then requester 1 after one IDLE cycle, then requester 0 again (round-robin). Without PSCAN_FAIR_EN, requester 0 is served repeatedly.
- rst pulsed during the 8th SHIFT cycle → gnt, done, busy and count go to 0 immediately. No done follows. A new req restarts from a cleared detector.
- req0 dropped mid-SHIFT → the job still completes with the correct count and a done pulse.
